npuarc_rtt_prdcr_arb: RTL and testbench

Consumer-side arbiter for RTT trace producers. It accepts trace messages from the core producer and the 17 SWE producer ports and serialises them round-robin into a single message stream toward the RTT message packer. Per-producer busy is returned to each producer, along with the aggregated busy. The block sits at the other end of the producer select/busy interface aggregated in the RTT glue logic.

---
 rtl/npuarc_rtt_pkg_defines.sv | 28 ++
 rtl/npuarc_rtt_prdcr_fifo.sv | 66 ++++++
 rtl/npuarc_rtt_prdcr_arb.sv | 89 ++++++++
 tb/tb_npuarc_rtt_prdcr_arb.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npuarc_rtt_pkg_defines.sv
// Shared RTT producer-arbiter definitions:
// producer count, source IDs and FIFO entry layout.
package npuarc_rtt_pkg_defines;

  localparam int NUM_PRDCR = 18;
  localparam int MSG_WDT   = 32;
  localparam int SRC_WDT   = 5;

  localparam logic [SRC_WDT-1:0] RTT_SRC_CORE = '0;

  function automatic logic [SRC_WDT-1:0] rtt_src_swe(
    input int unsigned k
  );
    return SRC_WDT'(k + 1);
  endfunction

  typedef enum logic [1:0] {
    FIFO_EMPTY,
    FIFO_ONE,
    FIFO_FULL
  } fifo_state_e;

  typedef struct packed {
    logic [SRC_WDT-1:0] src;
    logic [MSG_WDT-1:0] msg;
  } fifo_entry_t;

endpackage

// File: rtl/npuarc_rtt_prdcr_fifo.sv
// Two-entry output FIFO; head entry is a register
// so the consumer sees registered data.
module npuarc_rtt_prdcr_fifo
  import npuarc_rtt_pkg_defines::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  fifo_entry_t din,
  input  logic        pop,
  output logic        space,
  output logic        valid,
  output fifo_entry_t dout
);

  fifo_state_e state_q, state_d;
  fifo_entry_t head_q, tail_q;
  logic        wr, rd;

  assign space = (state_q != FIFO_FULL);
  assign valid = (state_q != FIFO_EMPTY);
  assign wr    = push & space;
  assign rd    = pop & valid;
  assign dout  = head_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FIFO_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FIFO_EMPTY: if (wr) state_d = FIFO_ONE;
      FIFO_ONE: begin
        if (wr && !rd)      state_d = FIFO_FULL;
        else if (rd && !wr) state_d = FIFO_EMPTY;
      end
      FIFO_FULL:  if (rd) state_d = FIFO_ONE;
      default:    state_d = FIFO_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      unique case (state_q)
        FIFO_EMPTY: if (wr) head_q <= din;
        FIFO_ONE: begin
          if (wr && rd) head_q <= din;
          else if (wr)  tail_q <= din;
        end
        FIFO_FULL: begin
          if (rd) begin
            head_q <= tail_q;
            tail_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/npuarc_rtt_prdcr_arb.sv
// Round-robin arbiter serialising RTT producer
// messages into one stream for the message packer.
module npuarc_rtt_prdcr_arb
  import npuarc_rtt_pkg_defines::*;
(
  input  logic                         rtt_clk,
  input  logic                         rst_a,
  input  logic [NUM_PRDCR-1:0]         prdcr_sel,
  input  logic [NUM_PRDCR*MSG_WDT-1:0] prdcr_msg,
  output logic [NUM_PRDCR-1:0]         prdcr_busy,
  output logic                         ored_prdcr_busy,
  output logic                         msg_valid,
  output logic [MSG_WDT-1:0]           msg_data,
  output logic [SRC_WDT-1:0]           msg_src,
  input  logic                         msg_ready,
  input  logic                         stall_clr,
  output logic [15:0]                  stall_cnt
);

  localparam logic [SRC_WDT:0] NUM_W = (SRC_WDT+1)'(NUM_PRDCR);
  localparam logic [SRC_WDT-1:0] LAST = SRC_WDT'(NUM_PRDCR-1);

  logic [SRC_WDT-1:0]   rr_ptr, off, win;
  logic [SRC_WDT:0]     sum;
  logic [NUM_PRDCR-1:0] req_rot, grant;
  logic                 hit, space, push, pop;
  fifo_entry_t          push_ent, head;

  // Rotate so rr_ptr lands on bit 0; lowest set bit is the winner.
  always_comb begin
    req_rot = NUM_PRDCR'({prdcr_sel, prdcr_sel} >> rr_ptr);
    off = '0;
    hit = 1'b0;
    for (int i = NUM_PRDCR-1; i >= 0; i--) begin
      if (req_rot[i]) begin
        off = SRC_WDT'(i);
        hit = 1'b1;
      end
    end
    sum = {1'b0, rr_ptr} + {1'b0, off};
    win = (sum >= NUM_W) ? SRC_WDT'(sum - NUM_W)
                         : SRC_WDT'(sum);
    grant = '0;
    if (rst_a && space && hit)
      grant = NUM_PRDCR'(1) << win;
  end

  always_comb begin
    push_ent     = '0;
    push_ent.src = win;
    for (int i = 0; i < NUM_PRDCR; i++) begin
      if (grant[i])
        push_ent.msg = prdcr_msg[i*MSG_WDT +: MSG_WDT];
    end
  end

  assign push            = |grant;
  assign pop             = msg_valid & msg_ready;
  assign prdcr_busy      = prdcr_sel & ~grant;
  assign ored_prdcr_busy = |prdcr_busy;
  assign msg_data        = head.msg;
  assign msg_src         = head.src;

  always_ff @(posedge rtt_clk or negedge rst_a) begin
    if (!rst_a)    rr_ptr <= '0;
    else if (push) rr_ptr <= (win == LAST) ? '0 : win + 1'b1;
  end

  always_ff @(posedge rtt_clk or negedge rst_a) begin
    if (!rst_a)
      stall_cnt <= '0;
    else if (stall_clr)
      stall_cnt <= '0;
    else if (ored_prdcr_busy && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end

  npuarc_rtt_prdcr_fifo u_fifo (
    .clk   (rtt_clk),
    .rst_n (rst_a),
    .push  (push),
    .din   (push_ent),
    .pop   (pop),
    .space (space),
    .valid (msg_valid),
    .dout  (head)
  );

endmodule

// File: tb/tb_npuarc_rtt_prdcr_arb.sv
// Self-checking bench for npuarc_rtt_prdcr_arb against
// a queue-based cycle model of the arbiter.
module tb_npuarc_rtt_prdcr_arb;

  localparam int N = 18;

  logic            rtt_clk = 1'b0;
  logic            rst_a;
  logic [N-1:0]    prdcr_sel;
  logic [N*32-1:0] prdcr_msg;
  logic [N-1:0]    prdcr_busy;
  logic            ored_prdcr_busy;
  logic            msg_valid;
  logic [31:0]     msg_data;
  logic [4:0]      msg_src;
  logic            msg_ready;
  logic            stall_clr;
  logic [15:0]     stall_cnt;

  logic [31:0] pm [N];

  always #5 rtt_clk = ~rtt_clk;

  always_comb begin
    for (int i = 0; i < N; i++) prdcr_msg[i*32 +: 32] = pm[i];
  end

  npuarc_rtt_prdcr_arb dut (
    .rtt_clk         (rtt_clk),
    .rst_a           (rst_a),
    .prdcr_sel       (prdcr_sel),
    .prdcr_msg       (prdcr_msg),
    .prdcr_busy      (prdcr_busy),
    .ored_prdcr_busy (ored_prdcr_busy),
    .msg_valid       (msg_valid),
    .msg_data        (msg_data),
    .msg_src         (msg_src),
    .msg_ready       (msg_ready),
    .stall_clr       (stall_clr),
    .stall_cnt       (stall_cnt)
  );

  typedef struct packed {
    logic [4:0]  src;
    logic [31:0] msg;
  } ent_t;

  ent_t         mq[$];
  int           m_ptr;
  int           m_stall;
  int           e_win;
  logic [N-1:0] e_busy;
  logic         e_valid;
  int           n_cmp = 0;
  int           n_bad = 0;

  function automatic void model_reset();
    mq.delete();
    m_ptr = 0;
    m_stall = 0;
    e_win = -1;
  endfunction

  // Expectations for the current cycle, from pre-edge state.
  function automatic void model_eval();
    int idx;
    e_win = -1;
    if (mq.size() < 2) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (e_win < 0 && prdcr_sel[idx]) e_win = idx;
      end
    end
    e_busy = prdcr_sel;
    if (e_win >= 0) e_busy[e_win] = 1'b0;
    e_valid = (mq.size() != 0);
  endfunction

  function automatic void model_commit();
    ent_t e;
    if (e_valid && msg_ready) void'(mq.pop_front());
    if (e_win >= 0) begin
      e.src = 5'(e_win);
      e.msg = pm[e_win];
      mq.push_back(e);
      m_ptr = (e_win == N-1) ? 0 : e_win + 1;
    end
    if (stall_clr) m_stall = 0;
    else if (e_busy != '0 && m_stall < 65535) m_stall++;
  endfunction

  task automatic half_a();
    @(negedge rtt_clk);
    model_eval();
  endtask

  task automatic half_b();
    @(posedge rtt_clk);
    model_commit();
    #1;
  endtask

  task automatic apply_reset();
    @(posedge rtt_clk);
    #1;
    prdcr_sel = '0;
    msg_ready = 1'b0;
    stall_clr = 1'b0;
    rst_a = 1'b0;
    @(negedge rtt_clk);
    rst_a = 1'b1;
    model_reset();
    @(posedge rtt_clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b0;
    msg_ready = 1'b0;
    stall_clr = 1'b0;
    for (int i = 0; i < N; i++) pm[i] = $urandom;
    prdcr_sel = N'($urandom) | N'(1);
    #3;
    n_cmp += 5;
    if (prdcr_busy !== prdcr_sel) begin
      n_bad++;
      $display("FAIL reset_busy got %h want %h", prdcr_busy, prdcr_sel);
    end
    if (msg_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_valid got %b want 0", msg_valid);
    end
    if (msg_data !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_data got %h want 0", msg_data);
    end
    if (msg_src !== 5'h0) begin
      n_bad++;
      $display("FAIL reset_src got %h want 0", msg_src);
    end
    if (stall_cnt !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_stall got %h want 0", stall_cnt);
    end
    apply_reset();
  endtask

  task automatic test_single();
    pm[0] = 32'hA5A5_0001;
    prdcr_sel = 18'h00001;
    msg_ready = 1'b1;
    half_a();
    n_cmp += 2;
    if (prdcr_busy[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL single_busy0 got %b want 0", prdcr_busy[0]);
    end
    if (msg_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_valid_c0 got %b want 0", msg_valid);
    end
    half_b();
    prdcr_sel = '0;
    half_a();
    n_cmp += 1;
    if (msg_valid !== 1'b1 || msg_src !== 5'd0 ||
        msg_data !== 32'hA5A5_0001) begin
      n_bad++;
      $display("FAIL single_out got v=%b s=%0d d=%h want v=1 s=0 d=a5a50001",
               msg_valid, msg_src, msg_data);
    end
    half_b();
  endtask

  task automatic test_all_requesting();
    int last [N];
    int w;
    apply_reset();
    for (int i = 0; i < N; i++) begin
      pm[i] = $urandom;
      last[i] = -1;
    end
    prdcr_sel = '1;
    msg_ready = 1'b1;
    for (int c = 0; c < 2*N + 2; c++) begin
      half_a();
      w = -1;
      for (int i = 0; i < N; i++)
        if (prdcr_sel[i] && !prdcr_busy[i]) w = i;
      n_cmp += 2;
      if (w != c % N) begin
        n_bad++;
        $display("FAIL all_order cyc %0d got %0d want %0d", c, w, c % N);
      end
      if (stall_cnt !== 16'(c)) begin
        n_bad++;
        $display("FAIL all_stall cyc %0d got %0d want %0d", c, stall_cnt, c);
      end
      if (w >= 0 && last[w] >= 0) begin
        n_cmp++;
        if (c - last[w] - 1 != N - 1) begin
          n_bad++;
          $display("FAIL all_gap prod %0d got %0d want %0d",
                   w, c - last[w] - 1, N - 1);
        end
      end
      if (e_valid) begin
        n_cmp++;
        if (msg_valid !== 1'b1 || msg_src !== mq[0].src ||
            msg_data !== mq[0].msg) begin
          n_bad++;
          $display("FAIL all_out cyc %0d got s=%0d d=%h want s=%0d d=%h",
                   c, msg_src, msg_data, mq[0].src, mq[0].msg);
        end
      end
      if (w >= 0) last[w] = c;
      half_b();
      if (w >= 0) pm[w] = $urandom;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] m2, m5;
    apply_reset();
    m2 = $urandom;
    m5 = $urandom;
    pm[2] = m2;
    pm[5] = m5;
    prdcr_sel = 18'h00024;
    half_a();
    n_cmp++;
    if (prdcr_busy !== 18'h00020) begin
      n_bad++;
      $display("FAIL bp_c0_busy got %h want 00020", prdcr_busy);
    end
    half_b();
    prdcr_sel = 18'h00020;
    half_a();
    n_cmp++;
    if (prdcr_busy !== 18'h0) begin
      n_bad++;
      $display("FAIL bp_c1_busy got %h want 0", prdcr_busy);
    end
    half_b();
    pm[2] = $urandom;
    pm[5] = $urandom;
    prdcr_sel = 18'h00024;
    for (int c = 2; c < 4; c++) begin
      half_a();
      n_cmp += 2;
      if (prdcr_busy !== 18'h00024) begin
        n_bad++;
        $display("FAIL bp_full_busy cyc %0d got %h want 00024", c, prdcr_busy);
      end
      if (msg_valid !== 1'b1 || msg_src !== 5'd2 || msg_data !== m2) begin
        n_bad++;
        $display("FAIL bp_head2 cyc %0d got v=%b s=%0d d=%h want s=2 d=%h",
                 c, msg_valid, msg_src, msg_data, m2);
      end
      half_b();
      msg_ready = 1'b1;
    end
    half_a();
    n_cmp += 2;
    if (msg_valid !== 1'b1 || msg_src !== 5'd5 || msg_data !== m5) begin
      n_bad++;
      $display("FAIL bp_head5 got v=%b s=%0d d=%h want s=5 d=%h",
               msg_valid, msg_src, msg_data, m5);
    end
    if (prdcr_busy !== 18'h00020) begin
      n_bad++;
      $display("FAIL bp_regrant got %h want 00020", prdcr_busy);
    end
    half_b();
    prdcr_sel = '0;
    for (int c = 0; c < 3; c++) begin
      half_a();
      half_b();
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    msg_ready = 1'b1;
    prdcr_sel = 18'h10000;
    half_a();
    half_b();
    prdcr_sel = 18'h20008;
    half_a();
    n_cmp++;
    if (prdcr_busy !== 18'h00008) begin
      n_bad++;
      $display("FAIL wrap_first got %h want 00008", prdcr_busy);
    end
    half_b();
    prdcr_sel = 18'h00008;
    half_a();
    n_cmp++;
    if (prdcr_busy !== 18'h0) begin
      n_bad++;
      $display("FAIL wrap_second got %h want 0", prdcr_busy);
    end
    half_b();
    prdcr_sel = '1;
    half_a();
    n_cmp++;
    if (prdcr_busy !== 18'h3FFEF) begin
      n_bad++;
      $display("FAIL wrap_ptr got %h want 3ffef", prdcr_busy);
    end
    half_b();
    prdcr_sel = '0;
    for (int c = 0; c < 3; c++) begin
      half_a();
      half_b();
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      msg_ready = ($urandom % 4) != 0;
      stall_clr = ($urandom % 64) == 0;
      half_a();
      n_cmp += 4;
      if (prdcr_busy !== e_busy) begin
        n_bad++;
        $display("FAIL rand_busy cyc %0d got %h want %h", c, prdcr_busy, e_busy);
      end
      if (ored_prdcr_busy !== |e_busy) begin
        n_bad++;
        $display("FAIL rand_ored cyc %0d got %b want %b",
                 c, ored_prdcr_busy, |e_busy);
      end
      if (msg_valid !== e_valid) begin
        n_bad++;
        $display("FAIL rand_valid cyc %0d got %b want %b", c, msg_valid, e_valid);
      end
      if (stall_cnt !== 16'(m_stall)) begin
        n_bad++;
        $display("FAIL rand_stall cyc %0d got %0d want %0d", c, stall_cnt, m_stall);
      end
      if (e_valid) begin
        n_cmp++;
        if (msg_src !== mq[0].src || msg_data !== mq[0].msg) begin
          n_bad++;
          $display("FAIL rand_out cyc %0d got s=%0d d=%h want s=%0d d=%h",
                   c, msg_src, msg_data, mq[0].src, mq[0].msg);
        end
      end
      half_b();
      for (int i = 0; i < N; i++) begin
        if (e_win == i) prdcr_sel[i] = 1'b0;
        if (!prdcr_sel[i] && ($urandom % 100) < 30) begin
          prdcr_sel[i] = 1'b1;
          pm[i] = $urandom;
        end
      end
    end
    stall_clr = 1'b0;
  endtask

  task automatic test_counter();
    apply_reset();
    prdcr_sel = '1;
    msg_ready = 1'b0;
    for (int c = 0; c < 70000; c++) begin
      half_a();
      half_b();
    end
    stall_clr = 1'b1;
    half_a();
    n_cmp += 2;
    if (stall_cnt !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL cnt_sat got %h want ffff", stall_cnt);
    end
    if (ored_prdcr_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL cnt_ored got %b want 1", ored_prdcr_busy);
    end
    half_b();
    stall_clr = 1'b0;
    half_a();
    n_cmp++;
    if (stall_cnt !== 16'h0) begin
      n_bad++;
      $display("FAIL cnt_clr got %h want 0", stall_cnt);
    end
    half_b();
  endtask

  task automatic test_reset_midop();
    logic [31:0] m3;
    #2;
    rst_a = 1'b0;
    #1;
    n_cmp += 4;
    if (msg_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_valid got %b want 0", msg_valid);
    end
    if (msg_data !== 32'h0 || msg_src !== 5'h0) begin
      n_bad++;
      $display("FAIL mid_data got s=%0d d=%h want 0", msg_src, msg_data);
    end
    if (stall_cnt !== 16'h0) begin
      n_bad++;
      $display("FAIL mid_stall got %h want 0", stall_cnt);
    end
    if (prdcr_busy !== prdcr_sel) begin
      n_bad++;
      $display("FAIL mid_busy got %h want %h", prdcr_busy, prdcr_sel);
    end
    m3 = $urandom;
    pm[3] = m3;
    prdcr_sel = 18'h00208;
    @(negedge rtt_clk);
    rst_a = 1'b1;
    model_reset();
    #1;
    model_eval();
    n_cmp++;
    if (prdcr_busy !== 18'h00200) begin
      n_bad++;
      $display("FAIL mid_first_grant got %h want 00200", prdcr_busy);
    end
    half_b();
    prdcr_sel = 18'h00200;
    half_a();
    n_cmp++;
    if (msg_valid !== 1'b1 || msg_src !== 5'd3 || msg_data !== m3) begin
      n_bad++;
      $display("FAIL mid_out got v=%b s=%0d d=%h want s=3 d=%h",
               msg_valid, msg_src, msg_data, m3);
    end
    half_b();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_all_requesting();
    test_backpressure();
    test_wrap();
    test_random();
    test_counter();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
